// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// Optional same-cycle read bypass is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic [1:0] {
    PC_INC   = 2'b00,
    PC_START = 2'b01,
    PC_DP    = 2'b11
  } pc_sel_t;

  function automatic int reg_pc_idx(input int num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_pc.sv
// Program counter: start/branch load or increment with wrap.
// Instantiated by regfile_sb (REGFILE_BYPASS_EN does not affect this unit).
module pc_unit
  import regfile_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      sel_pc_i,
  input  logic            load_pc_i,
  input  logic [PC_W-1:0] start_pc_i,
  input  logic [PC_W-1:0] dp_pc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  pc_sel_t         sel;

  assign sel = pc_sel_t'(sel_pc_i);

  always_comb begin
    pc_d = pc_q;
    if (load_pc_i) begin
      unique case (1'b1)
        (sel == PC_START): pc_d = start_pc_i;
        (sel == PC_DP):    pc_d = dp_pc_i;
        default:           pc_d = pc_q + PC_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with load scoreboard, PC and status registers.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  parameter  int PC_W     = 7,
  parameter  int NUM_RD   = 4,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_en1,
  input  logic [AW-1:0]            w_addr1,
  input  logic [DATA_W-1:0]        w_data1,
  input  logic                     w_en_ldr,
  input  logic [AW-1:0]            w_addr_ldr,
  input  logic [DATA_W-1:0]        w_data_ldr,
  input  logic                     issue_ldr,
  input  logic [AW-1:0]            issue_addr,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     busy_any,
  input  logic [1:0]               sel_pc,
  input  logic                     load_pc,
  input  logic [PC_W-1:0]          start_pc,
  input  logic [PC_W-1:0]          dp_pc,
  output logic [PC_W-1:0]          pc_out,
  input  logic                     en_status,
  input  logic [DATA_W-1:0]        status_in,
  output logic [DATA_W-1:0]        status_out,
  input  logic [AW-1:0]            dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int            REG_PC_I = reg_pc_idx(NUM_REGS);
  localparam logic [AW-1:0] REG_PC   = AW'(REG_PC_I);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [DATA_W-1:0]   status_q;
  logic [DATA_W-1:0]   status_d;
  logic [PC_W-1:0]     pc;
  logic [DATA_W-1:0]   pc_ext;

  pc_unit #(
    .PC_W(PC_W)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_pc_i  (sel_pc),
    .load_pc_i (load_pc),
    .start_pc_i(start_pc),
    .dp_pc_i   (dp_pc),
    .pc_o      (pc)
  );

  assign pc_ext = {{(DATA_W-PC_W){1'b0}}, pc};

  // Load write follows the datapath write so it wins a collision;
  // issue follows the clear so back-to-back loads stay busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i != REG_PC_I) begin
        if (w_en1 && w_addr1 == AW'(i)) begin
          regs_d[i] = w_data1;
        end
        if (w_en_ldr && w_addr_ldr == AW'(i)) begin
          regs_d[i] = w_data_ldr;
          busy_d[i] = 1'b0;
        end
        if (issue_ldr && issue_addr == AW'(i)) begin
          busy_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    status_d = status_q;
    if (en_status) begin
      status_d = status_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q   <= '0;
      status_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q   <= busy_d;
      status_q <= status_d;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = rd_addr[gi*AW +: AW];

    always_comb begin
      d = regs_q[a];
      b = busy_q[a];
      if (a == REG_PC) begin
        d = pc_ext;
        b = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else begin
        if (w_en1 && w_addr1 == a) begin
          d = w_data1;
        end
        if (w_en_ldr && w_addr_ldr == a) begin
          d = w_data_ldr;
          if (!(issue_ldr && issue_addr == a)) begin
            b = 1'b0;
          end
        end
      end
`endif
    end

    assign rd_data[gi*DATA_W +: DATA_W] = d;
    assign rd_busy[gi]                  = b;
  end

  assign busy_any   = |busy_q;
  assign pc_out     = pc;
  assign status_out = status_q;
  assign dbg_data   = (dbg_addr == REG_PC) ? pc_ext : regs_q[dbg_addr];

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the core register file: N general registers, K combinational read ports, two write ports (datapath writeback and load writeback), plus PC and status registers.
- Adds a per-register load scoreboard. The issue stage marks a destination busy when an LDR issues; the load writeback clears it. Readers see a busy flag so the controller can stall.
- Sits between the controller/datapath and the memory writeback path.

Parameters:
- DATA_W, 32, register and status width
- NUM_REGS, 16, architectural registers including PC; power of two, at least 4
- PC_W, 7, PC width (instruction memory address)
- NUM_RD, 4, number of combinational read ports
- AW, $clog2(NUM_REGS), address width (localparam)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- w_en1  in  1  datapath write enable
- w_addr1  in  AW  datapath write address
- w_data1  in  DATA_W  datapath write data
- w_en_ldr  in  1  load writeback enable
- w_addr_ldr  in  AW  load writeback address
- w_data_ldr  in  DATA_W  load writeback data
- issue_ldr  in  1  a load is issuing; marks its destination busy
- issue_addr  in  AW  destination of the issuing load
- rd_addr  in  NUM_RD*AW  packed read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  scoreboard bit of each addressed register
- busy_any  out  1  OR of all scoreboard bits
- sel_pc  in  2  PC source select
- load_pc  in  1  PC update enable
- start_pc  in  PC_W  start address
- dp_pc  in  PC_W  branch target from the datapath
- pc_out  out  PC_W  current PC
- en_status  in  1  status write enable
- status_in  in  DATA_W  status next value
- status_out  out  DATA_W  status register
- dbg_addr  in  AW  FPGA debug read address
- dbg_data  out  DATA_W  FPGA debug read data

Behaviour:
- Reset (rst_n low, asynchronous): all registers, pc, status and scoreboard cleared to 0. All outputs read 0 until the first write. Reset takes effect mid-operation, discarding pending loads.
- Index REG_PC = NUM_REGS-1 is the PC.
  - Reads of REG_PC on any read port or dbg return pc zero-extended to DATA_W, with busy 0.
  - Writes and issues to REG_PC are ignored by the array and the scoreboard.
- Reads are combinational from state; there is no same-cycle write-to-read bypass unless the optional feature is enabled.
- Writes take effect on the rising edge; write latency is 1 cycle.
- w_en1 and w_en_ldr to the same address in one cycle: load data wins. Different addresses: both written.
- Scoreboard, per register:
  - issue_ldr sets busy.
  - w_en_ldr clears busy.
  - Set and clear on the same address in the same cycle: set wins (back-to-back loads to one register).
  - w_en1 to a busy register writes the data and leaves busy unchanged.
  - w_en_ldr to a non-busy register writes the data; busy stays 0.
- PC, when load_pc = 1:
  - sel_pc 01 loads start_pc.
  - sel_pc 11 loads dp_pc.
  - 00 or 10 loads pc+1, modulo 2^PC_W (wrap-around from all-ones to 0).
  - When load_pc = 0 the PC holds.
- Status: loads status_in when en_status = 1, otherwise holds.
- busy_any is combinational from the scoreboard flops.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address matches an enabled same-cycle write (not REG_PC) returns the write data; load data has priority over w_en1, matching write priority.
  - rd_busy returns 0 for a register being cleared this cycle by w_en_ldr, unless issue_ldr targets it in the same cycle.
  - dbg is not bypassed.
- Undefined: reads reflect state only; the new value is visible one cycle after the write.

Decomposition:
- Package regfile_pkg:
  - Enum pc_sel_t: PC_INC=2'b00, PC_START=2'b01, PC_DP=2'b11.
  - Function reg_pc_idx(NUM_REGS).
- Sub-module pc_unit (PC_W): holds the PC register, the sel_pc mux and the increment/wrap logic.

Test Plan:
- Reset: assert rst_n=0 mid-run after writes → pc_out, status_out, all rd_data, rd_busy and busy_any read 0 asynchronously.
- Write collision: w_en1=1 and w_en_ldr=1 both to address 3, data 0xAAAA0000 and 0x12345678 → next cycle rd_data for address 3 = 0x12345678. A w_en1 write to address 15 leaves the PC unchanged.
- Scoreboard set/clear:
  - issue_ldr to address 5 → rd_busy=1, busy_any=1.
  - Next cycle w_en_ldr to 5 with 0xDEADBEEF plus issue_ldr to 5 → busy stays 1 and data = 0xDEADBEEF.
  - A lone clear on the following cycle → busy 0.
- PC sequencing with PC_W=7:
  - sel_pc=01, start_pc=0x7E → pc_out=0x7E.
  - Two increments → 0x7F, then 0x00.
  - sel_pc=11, dp_pc=0x10 → 0x10.
  - load_pc=0 → PC holds.
  - Reading address 15 → 0x00000010.
- Bypass (REGFILE_BYPASS_EN): w_en1 to address 2 with 0x55 while rd_addr port 0 = 2 → rd_data0 = 0x55 in the same cycle. Without the macro → the old value this cycle, 0x55 the next cycle.
